register_file_bank: RTL



---
 rtl/register_file_bank.sv | 123 ++++++++++++
 1 files changed

// File: rtl/register_file_bank.sv
// register_file_bank: NREG x WIDTH register file for the 16-bit datapath.
// Writes arrive through a valid/ready handshake. There are two combinational
// read ports, each with same-cycle write bypass. Register 0 is hardwired to
// zero. A sequenced clear engine zeroes r1..r(NREG-1), one register per cycle.
module register_file_bank #(
    parameter  int WIDTH = 16,
    parameter  int NREG  = 8,
    localparam int AW    = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_a_addr,
    output logic [WIDTH-1:0] rd_a_data,
    input  logic [AW-1:0]    rd_b_addr,
    output logic [WIDTH-1:0] rd_b_data,
    input  logic             clear_req,
    output logic             clear_busy
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    localparam logic [AW-1:0] LAST_REG = AW'(NREG - 1);

    state_e            state_q, state_d;
    logic [AW-1:0]     clr_cnt_q, clr_cnt_d;
    logic [WIDTH-1:0]  mem_q [NREG];
    logic              wr_fire;
    logic              wr_hit;

    // The handshake and the clear flag are decoded from registered state only.
    assign wr_ready   = (state_q == ST_IDLE);
    assign clear_busy = (state_q == ST_CLEAR);
    assign wr_fire    = wr_valid && wr_ready;
    // A write to r0 completes the handshake but is discarded.
    assign wr_hit     = wr_fire && (wr_addr != '0);

    // Next-state logic for the clear sequencer.
    always_comb begin
        // NOTE: assign every always_comb output a default first. A path that
        // leaves a signal unassigned would infer a latch.
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = AW'(1);
                end
            end
            ST_CLEAR: begin
                if (clr_cnt_q == LAST_REG) begin
                    state_d   = ST_IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + AW'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                clr_cnt_d = '0;
            end
        endcase
    end

    // Sequencer state register. Reset aborts any clear in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking (<=) assignments. All flops
        // then update together and simulation matches the synthesized logic.
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Storage update: commit the accepted write, or zero the register the
    // clear sequence is currently pointing at.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the storage array is reset on purpose, because reset must
            // leave every register reading zero. This costs a reset net on
            // every bit, so do not copy it into RAM-style arrays that do not
            // need it.
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wr_hit) begin
                mem_q[wr_addr] <= wr_data;
            end
            if (state_q == ST_CLEAR) begin
                mem_q[clr_cnt_q] <= '0;
            end
        end
    end

    // Combinational read ports. r0 is forced to zero. A write firing this
    // cycle to the addressed register is forwarded to the port.
    always_comb begin
        rd_a_data = mem_q[rd_a_addr];
        rd_b_data = mem_q[rd_b_addr];
        if (rd_a_addr == '0) begin
            rd_a_data = '0;
        end else if (wr_hit && (wr_addr == rd_a_addr)) begin
            rd_a_data = wr_data;
        end
        if (rd_b_addr == '0) begin
            rd_b_data = '0;
        end else if (wr_hit && (wr_addr == rd_b_addr)) begin
            rd_b_data = wr_data;
        end
    end

endmodule
